sd_data_receive: RTL and testbench

SD_DATA_RECEIVE -- requirements
Module: sd_data_receive

---
 rtl/sd_pkg.sv | 32 +++
 rtl/sd_crc16.sv | 24 ++
 rtl/sd_data_receive.sv | 220 ++++++++++++++++++++++
 tb/tb_sd_data_receive.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD DAT-line block receiver:
// FSM state encoding, CRC16 polynomial and lane-mode encodings.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        END_BIT
    } rx_state_e;

    typedef enum logic {
        LANE_MODE_1BIT = 1'b0,
        LANE_MODE_4BIT = 1'b1
    } lane_mode_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // One serial step of the CCITT CRC16, MSB-first
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

    // Lanes that carry data in a given mode
    function automatic logic [3:0] lane_mask(input lane_mode_e mode);
        return (mode == LANE_MODE_4BIT) ? 4'hF : 4'h1;
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 (poly 0x1021, init 0) for one DAT lane.
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        din,
    output logic [15:0] crc
);

    // Clear has priority so a new block always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'h0000;
        end else if (clear) begin
            crc <= 16'h0000;
        end else if (enable) begin
            crc <= crc16_next(crc, din);
        end
    end

endmodule

// File: rtl/sd_data_receive.sv
// SD card DAT-line block receiver: start-bit search with timeout,
// byte assembly in 1-bit or 4-bit mode, per-lane CRC16 check, end bit.
module sd_data_receive
    import sd_pkg::*;
#(
    parameter int DATA_LANES    = 4,
    parameter int BLOCK_BYTES   = 512,
    parameter int TIMEOUT_TICKS = 65535
) (
    input  logic                  ex_clk,
    input  logic                  ex_resetn,
    input  logic                  sd_clk_en,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  wide_bus,
    input  logic [DATA_LANES-1:0] sd_dat_in,
    output logic [7:0]            byte_data,
    output logic                  byte_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  crc_err,
    output logic                  end_err,
    output logic                  timeout_err
);

    localparam int BYTE_CNT_W = $clog2(BLOCK_BYTES + 1);
    localparam int TO_CNT_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BLOCK_BYTES - 1);
    localparam logic [TO_CNT_W-1:0]   LAST_TICK = TO_CNT_W'(TIMEOUT_TICKS - 1);

    rx_state_e             state_reg;
    lane_mode_e            mode_reg;
    logic [BYTE_CNT_W-1:0] byte_cnt_reg;
    logic [TO_CNT_W-1:0]   to_cnt_reg;
    logic [2:0]            bit_cnt_reg;
    logic [3:0]            crc_cnt_reg;
    logic [7:0]            shift_reg;
    logic [7:0]            byte_data_reg;
    logic                  byte_valid_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  crc_err_reg;
    logic                  end_err_reg;
    logic                  timeout_err_reg;

    logic [3:0]  dat4;
    logic [3:0]  active_mask;
    logic [3:0]  lane_bad;
    logic [3:0]  crc_en;
    logic [7:0]  shift_next;
    logic        tick;
    logic        start_accept;
    logic        start_bit;
    logic        end_bad;
    logic        last_bit;
    lane_mode_e  mode_sel;

    // Present the DAT lines as a uniform 4-lane vector; absent lanes read 0
    generate
        if (DATA_LANES == 4) begin : g_wide
            assign dat4 = sd_dat_in;
        end else begin : g_narrow
            assign dat4 = {3'b000, sd_dat_in[0]};
        end
    endgenerate

    assign mode_sel     = (DATA_LANES == 4 && wide_bus) ? LANE_MODE_4BIT : LANE_MODE_1BIT;
    assign active_mask  = lane_mask(mode_reg);
    assign tick         = sd_clk_en && !abort;
    assign start_accept = (state_reg == IDLE) && start && !abort;
    assign start_bit    = (dat4 & active_mask) == 4'h0;
    assign end_bad      = ((~dat4) & active_mask) != 4'h0;
    assign shift_next   = (mode_reg == LANE_MODE_4BIT) ? {shift_reg[3:0], dat4}
                                                       : {shift_reg[6:0], dat4[0]};
    assign last_bit     = (mode_reg == LANE_MODE_4BIT) ? (bit_cnt_reg == 3'd1)
                                                       : (bit_cnt_reg == 3'd7);
    assign crc_en       = (state_reg == DATA && tick) ? active_mask : 4'h0;

    // Per-lane generated CRC, received CRC shifter and mismatch detect
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [15:0] crc_calc;
            logic [15:0] rx_crc_reg;

            if (gi < DATA_LANES) begin : g_crc
                sd_crc16 u_crc16 (
                    .clk    (ex_clk),
                    .rst_n  (ex_resetn),
                    .clear  (start_accept),
                    .enable (crc_en[gi]),
                    .din    (dat4[gi]),
                    .crc    (crc_calc)
                );
            end else begin : g_no_crc
                assign crc_calc = 16'h0000;
            end

            // Shift in the card's CRC bits during the CRC phase
            always_ff @(posedge ex_clk or negedge ex_resetn) begin
                if (!ex_resetn) begin
                    rx_crc_reg <= 16'h0000;
                end else if (state_reg == CRC && tick) begin
                    rx_crc_reg <= {rx_crc_reg[14:0], dat4[gi]};
                end
            end

            // Includes the bit arriving on the current tick
            assign lane_bad[gi] = active_mask[gi] && ({rx_crc_reg[14:0], dat4[gi]} != crc_calc);
        end
    endgenerate

    // Main receive FSM; abort overrides everything, data moves only on ticks
    always_ff @(posedge ex_clk or negedge ex_resetn) begin
        if (!ex_resetn) begin
            state_reg       <= IDLE;
            mode_reg        <= LANE_MODE_1BIT;
            byte_cnt_reg    <= '0;
            to_cnt_reg      <= '0;
            bit_cnt_reg     <= 3'd0;
            crc_cnt_reg     <= 4'd0;
            shift_reg       <= 8'h00;
            byte_data_reg   <= 8'h00;
            byte_valid_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            crc_err_reg     <= 1'b0;
            end_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            if (abort) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            mode_reg        <= mode_sel;
                            crc_err_reg     <= 1'b0;
                            end_err_reg     <= 1'b0;
                            timeout_err_reg <= 1'b0;
                            byte_cnt_reg    <= '0;
                            to_cnt_reg      <= '0;
                            bit_cnt_reg     <= 3'd0;
                            crc_cnt_reg     <= 4'd0;
                            busy_reg        <= 1'b1;
                            state_reg       <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        if (tick) begin
                            if (start_bit) begin
                                state_reg <= DATA;
                            end else if (to_cnt_reg == LAST_TICK) begin
                                timeout_err_reg <= 1'b1;
                                done_reg        <= 1'b1;
                                busy_reg        <= 1'b0;
                                state_reg       <= IDLE;
                            end else begin
                                to_cnt_reg <= to_cnt_reg + TO_CNT_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            shift_reg <= shift_next;
                            if (last_bit) begin
                                bit_cnt_reg    <= 3'd0;
                                byte_data_reg  <= shift_next;
                                byte_valid_reg <= 1'b1;
                                byte_cnt_reg   <= byte_cnt_reg + BYTE_CNT_W'(1);
                                if (byte_cnt_reg == LAST_BYTE) begin
                                    crc_cnt_reg <= 4'd0;
                                    state_reg   <= CRC;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    CRC: begin
                        if (tick) begin
                            crc_cnt_reg <= crc_cnt_reg + 4'd1;
                            if (crc_cnt_reg == 4'd15) begin
                                if (lane_bad != 4'h0) begin
                                    crc_err_reg <= 1'b1;
                                end
                                state_reg <= END_BIT;
                            end
                        end
                    end
                    END_BIT: begin
                        if (tick) begin
                            if (end_bad) begin
                                end_err_reg <= 1'b1;
                            end
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign byte_data   = byte_data_reg;
    assign byte_valid  = byte_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign crc_err     = crc_err_reg;
    assign end_err     = end_err_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_sd_data_receive.sv
// Randomized bench for sd_data_receive: blocks are built as byte arrays,
// split into lane bit streams and CRC'd by polynomial long division.
module tb_sd_data_receive;

    localparam int LANES    = 4;
    localparam int BLOCK    = 512;
    localparam int TO_TICKS = 100;

    logic             ex_clk     = 1'b0;
    logic             ex_resetn  = 1'b0;
    logic             sd_clk_en  = 1'b0;
    logic             start      = 1'b0;
    logic             abort      = 1'b0;
    logic             wide_bus   = 1'b0;
    logic [LANES-1:0] sd_dat_in  = 4'hF;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             busy;
    logic             done;
    logic             crc_err;
    logic             end_err;
    logic             timeout_err;

    sd_data_receive #(
        .DATA_LANES    (LANES),
        .BLOCK_BYTES   (BLOCK),
        .TIMEOUT_TICKS (TO_TICKS)
    ) dut (
        .ex_clk      (ex_clk),
        .ex_resetn   (ex_resetn),
        .sd_clk_en   (sd_clk_en),
        .start       (start),
        .abort       (abort),
        .wide_bus    (wide_bus),
        .sd_dat_in   (sd_dat_in),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .busy        (busy),
        .done        (done),
        .crc_err     (crc_err),
        .end_err     (end_err),
        .timeout_err (timeout_err)
    );

    always #5 ex_clk = ~ex_clk;

    int         n_vec       = 0;
    int         n_err       = 0;
    int         done_cnt    = 0;
    int         overlap_err = 0;
    int         late_err    = 0;
    int         hold_err    = 0;
    bit         stray_start = 1'b0;
    logic [7:0] byte_q [$];
    logic [7:0] blk [BLOCK];
    logic [15:0] exp_crc [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    initial begin : monitor
        logic       prev_en;
        logic [7:0] last_byte;
        prev_en   = 1'b0;
        last_byte = 8'h00;
        forever begin
            @(negedge ex_clk);
            if (!ex_resetn) begin
                prev_en   = 1'b0;
                last_byte = 8'h00;
            end else begin
                if (byte_valid) begin
                    byte_q.push_back(byte_data);
                    if (!prev_en) late_err++;
                    last_byte = byte_data;
                end else if (byte_data !== last_byte) begin
                    hold_err++;
                end
                if (done) begin
                    done_cnt++;
                    if (busy) overlap_err++;
                end
                prev_en = sd_clk_en;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge ex_clk);
        #1;
    endtask

    // Gap cycles carry junk on the lines; the tick cycle carries d
    task automatic tick(input logic [3:0] d, input bit wide);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            sd_clk_en = 1'b0;
            sd_dat_in = 4'($urandom);
            step();
        end
        sd_clk_en = 1'b1;
        sd_dat_in = wide ? d : {3'($urandom), d[0]};
        step();
        sd_clk_en = 1'b0;
    endtask

    // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] crc_model(input bit bits[$]);
        bit [16:0] rem;
        rem = '0;
        for (int i = 0; i < bits.size() + 16; i++) begin
            rem = {rem[15:0], (i < bits.size()) ? bits[i] : 1'b0};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    task automatic compute_crcs(input bit wide);
        bit stream [$];
        for (int lane = 0; lane < 4; lane++) begin
            stream.delete();
            for (int b = 0; b < BLOCK; b++) begin
                if (wide) begin
                    stream.push_back(blk[b][4 + lane]);
                    stream.push_back(blk[b][lane]);
                end else if (lane == 0) begin
                    for (int k = 7; k >= 0; k--) stream.push_back(blk[b][k]);
                end
            end
            exp_crc[lane] = crc_model(stream);
        end
    endtask

    task automatic randomize_block();
        for (int b = 0; b < BLOCK; b++) blk[b] = 8'($urandom);
    endtask

    task automatic arm(input bit wide);
        wide_bus = wide;
        start    = 1'b1;
        step();
        start    = 1'b0;
        wide_bus = 1'($urandom);
        check("busy after start", 32'(busy), 1);
    endtask

    task automatic send_data(input bit wide, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            if (stray_start && b == 100) begin
                wide_bus = ~wide;
                start    = 1'b1;
                step();
                start    = 1'b0;
            end
            if (wide) begin
                tick(blk[b][7:4], 1'b1);
                tick(blk[b][3:0], 1'b1);
            end else begin
                for (int k = 7; k >= 0; k--) tick({3'b000, blk[b][k]}, 1'b0);
            end
        end
    endtask

    task automatic send_crc(input bit wide, input int nticks, input int flip_lane);
        logic [3:0] d;
        for (int k = 15; k > 15 - nticks; k--) begin
            for (int lane = 0; lane < 4; lane++) begin
                d[lane] = exp_crc[lane][k];
                if (lane == flip_lane && k == 0) d[lane] = ~d[lane];
            end
            tick(d, wide);
        end
    endtask

    // Full block: exp_crc must already hold the CRCs to transmit
    task automatic run_block(input bit wide, input int flip_lane, input bit endbit, input string tag);
        int         d0;
        logic [3:0] d;
        byte_q.delete();
        d0 = done_cnt;
        arm(wide);
        repeat ($urandom_range(0, 4)) tick(4'hF, wide);
        tick(4'h0, wide);
        send_data(wide, BLOCK);
        send_crc(wide, 16, flip_lane);
        if (endbit)    d = 4'hF;
        else if (wide) d = ~(4'b0001 << 2'($urandom_range(0, 3)));
        else           d = 4'hE;
        tick(d, wide);
        check({tag, " done"}, 32'(done), 1);
        check({tag, " busy at done"}, 32'(busy), 0);
        check({tag, " crc_err"}, 32'(crc_err), 32'(flip_lane >= 0));
        check({tag, " end_err"}, 32'(end_err), 32'(!endbit));
        check({tag, " timeout_err"}, 32'(timeout_err), 0);
        step();
        check({tag, " done pulse width"}, 32'(done), 0);
        check({tag, " done count"}, 32'(done_cnt - d0), 1);
        check({tag, " byte count"}, 32'(byte_q.size()), BLOCK);
        for (int i = 0; i < BLOCK && i < byte_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 32'(byte_q[i]), 32'(blk[i]));
        $display("block %s: wide=%0d bytes=%0d crc_err=%0d end_err=%0d", tag, wide,
                 byte_q.size(), crc_err, end_err);
    endtask

    initial begin : stimulus
        int d0;

        // Reset state
        repeat (3) step();
        check("rst byte_data", 32'(byte_data), 0);
        check("rst byte_valid", 32'(byte_valid), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst crc_err", 32'(crc_err), 0);
        check("rst end_err", 32'(end_err), 0);
        check("rst timeout_err", 32'(timeout_err), 0);
        ex_resetn = 1'b1;
        step();

        // 1-bit mode, all 0xFF, reference CRC constant
        for (int b = 0; b < BLOCK; b++) blk[b] = 8'hFF;
        exp_crc[0] = 16'h7FA1;
        exp_crc[1] = 16'h0000;
        exp_crc[2] = 16'h0000;
        exp_crc[3] = 16'h0000;
        run_block(1'b0, -1, 1'b1, "ff_1bit");

        // 4-bit mode, counting pattern
        for (int b = 0; b < BLOCK; b++) blk[b] = 8'(b);
        compute_crcs(1'b1);
        run_block(1'b1, -1, 1'b1, "count_4bit");

        // Same block, lane 2 CRC bit 0 inverted
        run_block(1'b1, 2, 1'b1, "badcrc_lane2");

        // Start bit timeout with lines held high
        byte_q.delete();
        d0 = done_cnt;
        arm(1'b1);
        repeat (TO_TICKS - 1) tick(4'hF, 1'b1);
        check("timeout no early done", 32'(done_cnt - d0), 0);
        check("timeout busy before limit", 32'(busy), 1);
        tick(4'hF, 1'b1);
        check("timeout done", 32'(done), 1);
        check("timeout_err", 32'(timeout_err), 1);
        check("timeout busy", 32'(busy), 0);
        check("timeout crc_err", 32'(crc_err), 0);
        step();
        check("timeout done pulse width", 32'(done), 0);
        check("timeout no bytes", 32'(byte_q.size()), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort idle keeps flag", 32'(timeout_err), 1);
        $display("block timeout: ticks=%0d timeout_err=%0d", TO_TICKS, timeout_err);

        // Abort after byte 10
        randomize_block();
        compute_crcs(1'b1);
        byte_q.delete();
        d0 = done_cnt;
        arm(1'b1);
        tick(4'h0, 1'b1);
        send_data(1'b1, 10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort byte_valid", 32'(byte_valid), 0);
        repeat (20) tick(4'($urandom), 1'b1);
        check("abort no done", 32'(done_cnt - d0), 0);
        check("abort byte count", 32'(byte_q.size()), 10);
        check("abort crc_err", 32'(crc_err), 0);
        $display("block abort: bytes=%0d busy=%0d", byte_q.size(), busy);

        // abort wins over a simultaneous start
        wide_bus = 1'b1;
        abort    = 1'b1;
        start    = 1'b1;
        step();
        abort    = 1'b0;
        start    = 1'b0;
        check("abort+start busy", 32'(busy), 0);
        step();
        check("abort+start busy later", 32'(busy), 0);

        // Fresh block after abort, with an ignored start mid-block
        randomize_block();
        compute_crcs(1'b1);
        stray_start = 1'b1;
        run_block(1'b1, -1, 1'b1, "after_abort");
        stray_start = 1'b0;

        // Reset during the CRC phase
        randomize_block();
        blk[BLOCK-1] = 8'h5A;
        compute_crcs(1'b1);
        arm(1'b1);
        tick(4'h0, 1'b1);
        send_data(1'b1, BLOCK);
        send_crc(1'b1, 8, -1);
        check("pre-reset busy", 32'(busy), 1);
        ex_resetn = 1'b0;
        #1;
        check("async rst byte_data", 32'(byte_data), 0);
        check("async rst byte_valid", 32'(byte_valid), 0);
        check("async rst busy", 32'(busy), 0);
        check("async rst done", 32'(done), 0);
        check("async rst flags", 32'({crc_err, end_err, timeout_err}), 0);
        step();
        step();
        ex_resetn = 1'b1;
        d0 = done_cnt;
        byte_q.delete();
        repeat (24) tick(4'($urandom), 1'b1);
        check("post-reset no done", 32'(done_cnt - d0), 0);
        check("post-reset busy", 32'(busy), 0);
        check("post-reset no bytes", 32'(byte_q.size()), 0);
        $display("block reset_in_crc: busy=%0d", busy);

        // Missing end bit
        randomize_block();
        compute_crcs(1'b1);
        run_block(1'b1, -1, 1'b0, "endbit0_4bit");

        // Random blocks in both modes
        randomize_block();
        compute_crcs(1'b1);
        run_block(1'b1, -1, 1'b1, "rand_4bit");
        randomize_block();
        compute_crcs(1'b0);
        run_block(1'b0, -1, 1'b1, "rand_1bit");
        randomize_block();
        compute_crcs(1'b0);
        run_block(1'b0, 0, 1'b0, "rand_1bit_errs");

        // Whole-run properties gathered by the monitor
        check("done overlaps busy", 32'(overlap_err), 0);
        check("byte_valid without tick", 32'(late_err), 0);
        check("byte_data hold", 32'(hold_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
